// File: rtl/aurora_rx_block_sorter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aurora_rx_block_sorter                                                     |
// | Block-lock tracking, data FIFO steering and control-block forwarding.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module aurora_rx_block_sorter #(
  parameter int FIFO_DEPTH = 8,
  parameter int LOCK_GOOD  = 32,
  parameter int LOCK_BAD   = 4
) (
  input  logic        clk_rx_i,
  input  logic        rst_n_i,
  input  logic [63:0] rx_data_i,
  input  logic [1:0]  rx_header_i,
  input  logic        rx_valid_i,
  output logic [63:0] data_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic [63:0] ctrl_o,
  output logic        ctrl_valid_o,
  output logic        lock_o,
  output logic [6:0]  fifo_level_o,
  output logic [15:0] hdr_err_cnt_o,
  output logic [15:0] ovf_cnt_o,
  input  logic        cnt_clr_i
);

  localparam int c_AW      = $clog2(FIFO_DEPTH);
  localparam int c_RUN_MAX = (LOCK_GOOD > LOCK_BAD) ? LOCK_GOOD : LOCK_BAD;
  localparam int c_RW      = $clog2(c_RUN_MAX + 1);
  localparam logic [c_RW-1:0] c_GOOD_LAST = c_RW'(LOCK_GOOD - 1);
  localparam logic [c_RW-1:0] c_BAD_LAST  = c_RW'(LOCK_BAD - 1);
  localparam logic [6:0]      c_DEPTH     = 7'(FIFO_DEPTH);
  localparam logic [7:0]      c_IDLE_TYPE = 8'h78;

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_RW-1:0]   r_run, w_run_nxt;

  logic [63:0]       r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_AW-1:0]   w_rd_ptr_inc;
  logic [6:0]        r_level;
  logic [63:0]       r_data;
  logic [63:0]       r_ctrl;
  logic              r_ctrl_valid;
  logic [15:0]       r_hdr_err;
  logic [15:0]       r_ovf;

  logic w_hdr_ok, w_hdr_bad, w_locked;
  logic w_wr_req, w_full, w_pop, w_wr_en, w_ovf, w_ctrl_fwd;

  assign w_hdr_ok  = (rx_header_i == 2'b01) || (rx_header_i == 2'b10);
  assign w_hdr_bad = rx_valid_i && !w_hdr_ok;
  assign w_locked  = (r_state == ST_LOCKED);

  // Forwarding decisions use the lock state held before the current block.
  assign w_wr_req   = rx_valid_i && w_locked && (rx_header_i == 2'b01);
  assign w_ctrl_fwd = rx_valid_i && w_locked && (rx_header_i == 2'b10) &&
                      (rx_data_i[63:56] != c_IDLE_TYPE);
  assign w_full     = (r_level == c_DEPTH);
  assign w_pop      = data_valid_o && data_ready_i;
  assign w_wr_en    = w_wr_req && (!w_full || w_pop);
  assign w_ovf      = w_wr_req && w_full && !w_pop;
  assign w_rd_ptr_inc = r_rd_ptr + c_AW'(1);

  always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_UNLOCKED;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    if (rx_valid_i) begin
      if (r_state == ST_UNLOCKED) begin
        if (!w_hdr_ok) begin
          w_run_nxt = '0;
        end else if (r_run == c_GOOD_LAST) begin
          w_state_nxt = ST_LOCKED;
          w_run_nxt   = '0;
        end else begin
          w_run_nxt = r_run + c_RW'(1);
        end
      end else begin
        if (w_hdr_ok) begin
          w_run_nxt = '0;
        end else if (r_run == c_BAD_LAST) begin
          w_state_nxt = ST_UNLOCKED;
          w_run_nxt   = '0;
        end else begin
          w_run_nxt = r_run + c_RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_rx_i) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= rx_data_i;
    end
  end

  always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_data   <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      if (w_wr_en && !w_pop) begin
        r_level <= r_level + 7'd1;
      end else if (!w_wr_en && w_pop) begin
        r_level <= r_level - 7'd1;
      end
      // Registered show-ahead head: next entry, or the incoming block when it becomes the head.
      if (w_pop) begin
        if (r_level > 7'd1) begin
          r_data <= r_mem[w_rd_ptr_inc];
        end else if (w_wr_en) begin
          r_data <= rx_data_i;
        end
      end else if (w_wr_en && (r_level == 7'd0)) begin
        r_data <= rx_data_i;
      end
    end
  end

  always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ctrl       <= '0;
      r_ctrl_valid <= 1'b0;
    end else begin
      r_ctrl_valid <= w_ctrl_fwd;
      if (w_ctrl_fwd) begin
        r_ctrl <= rx_data_i;
      end
    end
  end

  always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hdr_err <= '0;
      r_ovf     <= '0;
    end else if (cnt_clr_i) begin
      r_hdr_err <= '0;
      r_ovf     <= '0;
    end else begin
      if (w_hdr_bad && (r_hdr_err != 16'hFFFF)) begin
        r_hdr_err <= r_hdr_err + 16'd1;
      end
      if (w_ovf && (r_ovf != 16'hFFFF)) begin
        r_ovf <= r_ovf + 16'd1;
      end
    end
  end

  assign data_o        = r_data;
  assign data_valid_o  = (r_level != 7'd0);
  assign ctrl_o        = r_ctrl;
  assign ctrl_valid_o  = r_ctrl_valid;
  assign lock_o        = w_locked;
  assign fifo_level_o  = r_level;
  assign hdr_err_cnt_o = r_hdr_err;
  assign ovf_cnt_o     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_aurora_rx_block_sorter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aurora_rx_block_sorter                                                  |
// | Scoreboard bench with a queue-based reference model of the block sorter.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_aurora_rx_block_sorter;

  localparam int DEPTH = 8;
  localparam int GOOD  = 32;
  localparam int BAD   = 4;

  logic        clk_rx_i = 1'b0;
  logic        rst_n_i;
  logic [63:0] rx_data_i;
  logic [1:0]  rx_header_i;
  logic        rx_valid_i;
  logic [63:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i;
  logic [63:0] ctrl_o;
  logic        ctrl_valid_o;
  logic        lock_o;
  logic [6:0]  fifo_level_o;
  logic [15:0] hdr_err_cnt_o;
  logic [15:0] ovf_cnt_o;
  logic        cnt_clr_i;

  aurora_rx_block_sorter #(
    .FIFO_DEPTH (DEPTH),
    .LOCK_GOOD  (GOOD),
    .LOCK_BAD   (BAD)
  ) dut (
    .clk_rx_i      (clk_rx_i),
    .rst_n_i       (rst_n_i),
    .rx_data_i     (rx_data_i),
    .rx_header_i   (rx_header_i),
    .rx_valid_i    (rx_valid_i),
    .data_o        (data_o),
    .data_valid_o  (data_valid_o),
    .data_ready_i  (data_ready_i),
    .ctrl_o        (ctrl_o),
    .ctrl_valid_o  (ctrl_valid_o),
    .lock_o        (lock_o),
    .fifo_level_o  (fifo_level_o),
    .hdr_err_cnt_o (hdr_err_cnt_o),
    .ovf_cnt_o     (ovf_cnt_o),
    .cnt_clr_i     (cnt_clr_i)
  );

  always #5 clk_rx_i = ~clk_rx_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_locked;
  int          m_run;
  int          m_level;
  int          m_hdr_err;
  int          m_ovf;
  bit          m_ctrl_pulse;
  logic [63:0] exp_q[$];
  logic [63:0] ctrl_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_run = 0; m_level = 0; m_hdr_err = 0; m_ovf = 0; m_ctrl_pulse = 0;
    exp_q.delete();
    ctrl_q.delete();
  endtask

  // Drive one cycle of inputs, then advance the model across the sampling edge.
  task automatic step(input logic v, input logic [1:0] h, input logic [63:0] d,
                      input logic rdy, input logic clr);
    bit pop, wr, good;
    rx_valid_i = v; rx_header_i = h; rx_data_i = d; data_ready_i = rdy; cnt_clr_i = clr;
    @(posedge clk_rx_i);
    pop  = (m_level > 0) && rdy;
    wr   = v && m_locked && (h == 2'b01);
    good = (h == 2'b01) || (h == 2'b10);
    m_ctrl_pulse = v && m_locked && (h == 2'b10) && (d[63:56] != 8'h78);
    if (m_ctrl_pulse) ctrl_q.push_back(d);
    if (wr && (m_level < DEPTH || pop)) begin
      exp_q.push_back(d);
      m_level++;
    end else if (wr && m_ovf < 65535) begin
      m_ovf++;
    end
    if (pop) m_level--;
    if (v && !good && m_hdr_err < 65535) m_hdr_err++;
    if (clr) begin m_hdr_err = 0; m_ovf = 0; end
    if (v) begin
      if (!m_locked) begin
        m_run = good ? m_run + 1 : 0;
        if (m_run == GOOD) begin m_locked = 1; m_run = 0; end
      end else begin
        m_run = good ? 0 : m_run + 1;
        if (m_run == BAD) begin m_locked = 0; m_run = 0; end
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 64'h0, rdy, 1'b0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: sampled mid-cycle, consumes scoreboard entries as the DUT presents them.
  always @(negedge clk_rx_i) begin
    logic [63:0] e;
    chk("lock_o", {63'd0, lock_o}, {63'd0, m_locked});
    chk("fifo_level_o", {57'd0, fifo_level_o}, 64'(m_level));
    chk("data_valid_o", {63'd0, data_valid_o}, {63'd0, m_level != 0});
    chk("hdr_err_cnt_o", {48'd0, hdr_err_cnt_o}, 64'(m_hdr_err));
    chk("ovf_cnt_o", {48'd0, ovf_cnt_o}, 64'(m_ovf));
    chk("ctrl_valid_o", {63'd0, ctrl_valid_o}, {63'd0, m_ctrl_pulse});
    if (data_valid_o && data_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("data_o_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("data_o", data_o, e);
      end
    end
    if (ctrl_valid_o) begin
      if (ctrl_q.size() == 0) begin
        chk("ctrl_o_unexpected", 64'd1, 64'd0);
      end else begin
        e = ctrl_q.pop_front();
        chk("ctrl_o", ctrl_o, e);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_o"}, data_o, 64'd0);
    chk({tag, "_ctrl_o"}, ctrl_o, 64'd0);
    chk({tag, "_outs"}, {data_valid_o, ctrl_valid_o, lock_o, fifo_level_o, hdr_err_cnt_o, ovf_cnt_o}, 64'd0);
  endtask

  initial begin
    logic [15:0] ovf_before;
    int r;
    logic [1:0] h;
    logic [63:0] d;
    rst_n_i = 1'b0; rx_valid_i = 1'b0; rx_header_i = 2'b00; rx_data_i = '0;
    data_ready_i = 1'b0; cnt_clr_i = 1'b0;
    model_reset();
    #2;
    chk_all_zero("reset");
    @(posedge clk_rx_i); #1;
    rst_n_i = 1'b1;

    // Lock acquisition; the LOCK_GOOD-th block itself is not forwarded.
    for (int i = 0; i < GOOD; i++) step(1'b1, 2'b01, 64'(100 + i), 1'b0, 1'b0);
    chk("lock_after_32", {63'd0, lock_o}, 64'd1);
    step(1'b1, 2'b01, 64'h1, 1'b0, 1'b0);
    chk("first_data_valid", {63'd0, data_valid_o}, 64'd1);
    chk("first_data_o", data_o, 64'h1);

    // Overflow: 10 blocks into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) step(1'b1, 2'b01, 64'(64'hA000 + i), 1'b0, 1'b0);
    chk("ovf_level", {57'd0, fifo_level_o}, 64'd8);
    chk("ovf_cnt", {48'd0, ovf_cnt_o}, 64'd2);
    idle(9, 1'b1);
    chk("drained_level", {57'd0, fifo_level_o}, 64'd0);

    // Control forwarding: idle type discarded, other types pulse once.
    step(1'b1, 2'b10, 64'h7800_1234_5678_9ABC, 1'b0, 1'b0);
    chk("idle_no_pulse", {63'd0, ctrl_valid_o}, 64'd0);
    step(1'b1, 2'b10, 64'h1E00_0000_0000_0001, 1'b0, 1'b0);
    chk("ctrl_pulse", {63'd0, ctrl_valid_o}, 64'd1);
    chk("ctrl_value", ctrl_o, 64'h1E00_0000_0000_0001);
    idle(1, 1'b0);
    chk("ctrl_pulse_end", {63'd0, ctrl_valid_o}, 64'd0);
    chk("ctrl_hold", ctrl_o, 64'h1E00_0000_0000_0001);

    // Full FIFO with simultaneous write and pop.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'b01, rnd64() & 64'h00FF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    chk("full_level", {57'd0, fifo_level_o}, 64'd8);
    ovf_before = ovf_cnt_o;
    step(1'b1, 2'b01, 64'h5555_AAAA_0000_FFFF, 1'b1, 1'b0);
    chk("full_wr_pop_level", {57'd0, fifo_level_o}, 64'd8);
    chk("full_wr_pop_ovf", {48'd0, ovf_cnt_o}, {48'd0, ovf_before});
    idle(DEPTH + 1, 1'b1);

    // Lock loss: 3 bad, 1 good, 4 bad.
    step(1'b0, 2'b00, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 64'h0, 1'b1, 1'b0);
    step(1'b1, 2'b01, 64'hBEEF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 64'h0, 1'b1, 1'b0);
    chk("lock_held", {63'd0, lock_o}, 64'd1);
    step(1'b1, 2'b00, 64'h0, 1'b1, 1'b0);
    chk("lock_dropped", {63'd0, lock_o}, 64'd0);
    chk("hdr_err_7", {48'd0, hdr_err_cnt_o}, 64'd7);
    step(1'b1, 2'b11, 64'h0, 1'b1, 1'b1);
    chk("clr_priority", {48'd0, hdr_err_cnt_o}, 64'd0);
    idle(2, 1'b1);

    // Mid-stream reset with 5 entries buffered.
    for (int i = 0; i < GOOD; i++) step(1'b1, 2'b01, 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 64'(64'hC0 + i), 1'b0, 1'b0);
    chk("pre_reset_level", {57'd0, fifo_level_o}, 64'd5);
    #1 rst_n_i = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    @(posedge clk_rx_i); #1;
    rst_n_i = 1'b1;
    for (int i = 0; i < GOOD - 1; i++) step(1'b1, 2'b01, 64'(i), 1'b1, 1'b0);
    chk("no_lock_31", {63'd0, lock_o}, 64'd0);
    step(1'b1, 2'b01, 64'h0, 1'b1, 1'b0);
    chk("relock_32", {63'd0, lock_o}, 64'd1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      d = rnd64();
      if (r < 80) h = 2'b01;
      else if (r < 95) begin
        h = 2'b10;
        if ($urandom_range(0, 1) == 0) d[63:56] = 8'h78;
      end else h = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      step($urandom_range(0, 99) < 85, h, d, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) == 0);
    end
    idle(DEPTH + 2, 1'b1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("ctrl_queue_empty", 64'(ctrl_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aurora_rx_block_sorter.md
AURORA_RX_BLOCK_SORTER -- requirements
Module: aurora_rx_block_sorter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning data FIFO entries (power of 2, 4..64).
REQ-002 SHALL have parameter LOCK_GOOD, default 32, meaning consecutive valid-header blocks required to enter LOCKED.
REQ-003 SHALL have parameter LOCK_BAD, default 4, meaning consecutive invalid-header blocks required to leave LOCKED.
REQ-004 SHALL use one clock and asynchronous active-low reset: clk_rx_i  in  1  sole clock, all logic on rising edge.
REQ-005 rst_n_i  in  1  asynchronous active-low reset.
REQ-006 rx_data_i  in  64  descrambled block payload from aurora_rx_lane.
REQ-007 rx_header_i  in  2  sync header (01 data, 10 control, 00/11 invalid).
REQ-008 rx_valid_i  in  1  qualifies rx_data_i/rx_header_i for one cycle.
REQ-009 data_o  in/out: out  64  FIFO head payload.
REQ-010 data_valid_o  out  1  FIFO non-empty.
REQ-011 data_ready_i  in  1  consumer accepts head when data_valid_o high.
REQ-012 ctrl_o  out  64  last forwarded control block payload.
REQ-013 ctrl_valid_o  out  1  one-cycle pulse qualifying ctrl_o.
REQ-014 lock_o  out  1  lock FSM in LOCKED.
REQ-015 fifo_level_o  out  7  current FIFO occupancy.
REQ-016 hdr_err_cnt_o  out  16  saturating invalid-header count.
REQ-017 ovf_cnt_o  out  16  saturating count of data blocks dropped on full FIFO.
REQ-018 cnt_clr_i  in  1  synchronous clear of both counters.

Function
REQ-019 SHALL sample inputs only when rx_valid_i=1; cycles with rx_valid_i=0 change no lock, counter or FIFO-write state.
REQ-020 Lock FSM SHALL have states UNLOCKED and LOCKED with run counter good_run/bad_run.
- UNLOCKED: valid header increments good_run, invalid header resets to 0; good_run reaching LOCK_GOOD -> LOCKED, counter cleared.
- LOCKED: invalid header increments bad_run, valid header resets to 0; bad_run reaching LOCK_BAD -> UNLOCKED, counter cleared.
REQ-021 Forwarding SHALL use FSM state registered before the current block; the block completing LOCK_GOOD is not forwarded, the block completing LOCK_BAD is not forwarded (invalid anyway).
REQ-022 In LOCKED, header 01 SHALL write rx_data_i to FIFO; data_valid_o rises the cycle after the write into an empty FIFO (1-cycle latency), data_o is show-ahead.
REQ-023 In LOCKED, header 10 with rx_data_i[63:56]=8'h78 (idle) SHALL be discarded; any other type SHALL drive ctrl_o=rx_data_i and pulse ctrl_valid_o one cycle later.
REQ-024 Every invalid header (00/11) SHALL increment hdr_err_cnt_o in either state, saturating at 16'hFFFF.
REQ-025 FIFO pop SHALL occur when data_valid_o & data_ready_i; data_o, data_valid_o update next cycle.
REQ-026 Full FIFO with write and pop same cycle SHALL accept the write; level unchanged.
REQ-027 Full FIFO with write and no pop SHALL drop the block, leave contents unchanged, increment ovf_cnt_o (saturating).
REQ-028 Empty FIFO with write and data_ready_i=1 SHALL not pop (no bypass); level becomes 1.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_level_o ranges 0..FIFO_DEPTH.
REQ-030 LOCKED->UNLOCKED SHALL NOT flush the FIFO; contents drain normally.
REQ-031 cnt_clr_i SHALL zero both counters next cycle, with priority over any same-cycle increment.
REQ-032 data_o and ctrl_o SHALL hold their last value when not qualified.

Reset
REQ-033 rst_n_i low SHALL immediately force: FSM UNLOCKED, run counters 0, FIFO empty, pointers 0, data_valid_o=0, ctrl_valid_o=0, lock_o=0, fifo_level_o=0, counters 0, data_o=0, ctrl_o=0.
REQ-034 Reset asserted mid-operation SHALL discard FIFO contents and in-flight ctrl pulse; release SHALL require a full LOCK_GOOD run before forwarding resumes.

Verification
REQ-035 32 blocks hdr 01 rx_valid_i=1 each cycle -> lock_o=1 after 32nd; 33rd block (data 64'h1) appears on data_o with data_valid_o one cycle later.
REQ-036 LOCKED, data_ready_i=0, 10 data blocks -> fifo_level_o=8, ovf_cnt_o=2; then data_ready_i=1 -> 8 blocks out in order, fifo_level_o=0.
REQ-037 LOCKED, hdr 10 payload 64'h78xx.. -> no ctrl_valid_o; payload 64'h1E00_0000_0000_0001 -> ctrl_valid_o pulse 1 cycle, ctrl_o equal.
REQ-038 LOCKED, 3 invalid headers, 1 valid, 4 invalid -> lock_o stays 1 then drops after 4th; hdr_err_cnt_o=7.
REQ-039 Full FIFO with simultaneous write+pop -> level stays 8, ovf_cnt_o unchanged; cnt_clr_i with invalid header same cycle -> hdr_err_cnt_o=0.
REQ-040 rst_n_i pulsed low mid-stream with level 5 -> all outputs zero same cycle; 31 good blocks after release -> lock_o=0.
